// File: rtl/hp_manager_if.sv
// Event inputs and heart-display outputs of the HP manager.
// The game logic holds the master side; hp_manager holds the slave side.
interface hp_manager_if;
  logic       game_start;
  logic       hit_pulse;
  logic       heal_pulse;
  logic       frame_tick;
  logic [2:0] HP_value;
  logic       HP_enable;
  logic       invuln;
  logic       gameover;
  logic       dead_pulse;

  modport master (
    output game_start, hit_pulse, heal_pulse, frame_tick,
    input  HP_value, HP_enable, invuln, gameover, dead_pulse
  );

  modport slave (
    input  game_start, hit_pulse, heal_pulse, frame_tick,
    output HP_value, HP_enable, invuln, gameover, dead_pulse
  );
endinterface

// File: rtl/hp_manager.sv
// Player hit-point tracker: saturating HP, post-hit invulnerability window
// counted in frames with blinking hearts, and game-over detection.
module hp_manager #(
  parameter int unsigned HP_MAX        = 5,
  parameter int unsigned HP_INIT       = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned BLINK_BIT     = 3
) (
  input  logic        clk,
  input  logic        rst,
  hp_manager_if.slave bus
);

  localparam int unsigned HP_W  = 3;
  localparam int unsigned CNT_W = $clog2(INVULN_FRAMES + 1);

  localparam logic [HP_W-1:0]  HP_TOP   = HP_W'(HP_MAX);
  localparam logic [HP_W-1:0]  HP_START = HP_W'(HP_INIT);
  localparam logic [CNT_W-1:0] INV_LOAD = CNT_W'(INVULN_FRAMES);

  if (HP_MAX > 7 || HP_MAX < 1) begin : g_chk_hp_max
    $error("hp_manager: HP_MAX must be in 1..7");
  end
  if (HP_INIT < 1 || HP_INIT > HP_MAX) begin : g_chk_hp_init
    $error("hp_manager: HP_INIT must be in 1..HP_MAX");
  end
  if (INVULN_FRAMES < 1 || CNT_W < BLINK_BIT + 1) begin : g_chk_cnt
    $error("hp_manager: invulnerability counter too narrow for BLINK_BIT");
  end

  typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} state_t;

  state_t           state;
  logic [CNT_W-1:0] inv_cnt;
  logic [CNT_W-1:0] cnt_dec;
  logic [HP_W-1:0]  hp_healed;

  assign cnt_dec   = inv_cnt - CNT_W'(1);
  assign hp_healed = (bus.HP_value < HP_TOP) ? bus.HP_value + HP_W'(1) : bus.HP_value;

  // HP_enable is registered from the next state/counter so it lines up with invuln.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      inv_cnt        <= '0;
      bus.HP_value   <= '0;
      bus.HP_enable  <= 1'b0;
      bus.invuln     <= 1'b0;
      bus.gameover   <= 1'b0;
      bus.dead_pulse <= 1'b0;
    end else begin
      bus.dead_pulse <= 1'b0;
      if (bus.game_start) begin
        state         <= ALIVE;
        inv_cnt       <= '0;
        bus.HP_value  <= HP_START;
        bus.HP_enable <= 1'b1;
        bus.invuln    <= 1'b0;
        bus.gameover  <= 1'b0;
      end else begin
        case (state)
          ALIVE: begin
            if (bus.hit_pulse && (bus.heal_pulse || bus.HP_value > HP_W'(1))) begin
              // A same-cycle heal cancels the damage but the hit still grants invulnerability.
              if (!bus.heal_pulse) bus.HP_value <= bus.HP_value - HP_W'(1);
              state         <= INVULN;
              inv_cnt       <= INV_LOAD;
              bus.invuln    <= 1'b1;
              bus.HP_enable <= INV_LOAD[BLINK_BIT];
            end else if (bus.hit_pulse) begin
              state          <= DEAD;
              bus.HP_value   <= '0;
              bus.HP_enable  <= 1'b0;
              bus.gameover   <= 1'b1;
              bus.dead_pulse <= 1'b1;
            end else if (bus.heal_pulse) begin
              bus.HP_value <= hp_healed;
            end
          end
          INVULN: begin
            if (bus.heal_pulse) bus.HP_value <= hp_healed;
            if (bus.frame_tick) begin
              if (inv_cnt <= CNT_W'(1)) begin
                state         <= ALIVE;
                inv_cnt       <= '0;
                bus.invuln    <= 1'b0;
                bus.HP_enable <= 1'b1;
              end else begin
                inv_cnt       <= cnt_dec;
                bus.HP_enable <= cnt_dec[BLINK_BIT];
              end
            end
          end
          default: ;  // IDLE and DEAD hold until game_start or rst
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hp_manager.sv
// Self-checking bench for hp_manager: directed vector table, hand-written
// multi-cycle sequences and random traffic against a frame-count model.
module tb_hp_manager;

  localparam int HP_MAX = 5;
  localparam int HP_INIT = 3;
  localparam int INV_FRAMES = 60;
  localparam int BLINK = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hp_manager_if bus();

  hp_manager dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: playing/dead flags plus frames of invulnerability left.
  bit m_playing, m_dead, m_dp;
  int m_hp, m_left;

  task automatic model_step(input bit r, gs, hit, heal, tick);
    if (r) begin
      m_playing = 0; m_dead = 0; m_dp = 0; m_hp = 0; m_left = 0;
    end else begin
      m_dp = 0;
      if (gs) begin
        m_playing = 1; m_dead = 0; m_hp = HP_INIT; m_left = 0;
      end else if (m_playing) begin
        if (m_left > 0) begin
          if (heal && m_hp < HP_MAX) m_hp++;
          if (tick) m_left--;
        end else if (hit && heal) begin
          m_left = INV_FRAMES;
        end else if (hit && m_hp > 1) begin
          m_hp--; m_left = INV_FRAMES;
        end else if (hit) begin
          m_hp = 0; m_playing = 0; m_dead = 1; m_dp = 1;
        end else if (heal && m_hp < HP_MAX) begin
          m_hp++;
        end
      end
    end
  endtask

  function automatic int model_en();
    if (!m_playing) return 0;
    if (m_left == 0) return 1;
    return (m_left >> BLINK) & 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, gs, hit, heal, tick);
    rst = r;
    bus.game_start = gs; bus.hit_pulse = hit; bus.heal_pulse = heal; bus.frame_tick = tick;
    @(posedge clk);
    model_step(r, gs, hit, heal, tick);
    #1;
    check("model_hp",     int'(bus.HP_value),   m_hp);
    check("model_enable", int'(bus.HP_enable),  model_en());
    check("model_invuln", int'(bus.invuln),     int'(m_playing && m_left > 0));
    check("model_over",   int'(bus.gameover),   int'(m_dead));
    check("model_dead",   int'(bus.dead_pulse), int'(m_dp));
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 1);
  endtask

  typedef struct {
    bit r, gs, hit, heal, tick;
    int hp, en, inv, go, dp;
  } vec_t;

  function automatic vec_t mk(input bit r, gs, hit, heal, tick, input int hp, en, inv, go, dp);
    vec_t v;
    v.r = r; v.gs = gs; v.hit = hit; v.heal = heal; v.tick = tick;
    v.hp = hp; v.en = en; v.inv = inv; v.go = go; v.dp = dp;
    return v;
  endfunction

  vec_t vecs[22];

  initial begin
    bus.game_start = 0; bus.hit_pulse = 0; bus.heal_pulse = 0; bus.frame_tick = 0;

    //                 r gs hit heal tick  hp en inv go dp
    vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, 0, 0,  3, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0,  4, 1, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 0,  5, 1, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0,  5, 1, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1, 0, 0,  4, 1, 1, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 0,  4, 1, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 0,  5, 1, 1, 0, 0);
    vecs[12] = mk(0, 1, 1, 0, 0,  3, 1, 0, 0, 0);
    vecs[13] = mk(0, 0, 1, 1, 0,  3, 1, 1, 0, 0);
    vecs[14] = mk(0, 1, 0, 0, 0,  3, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 1, 0, 1,  2, 1, 1, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 1,  2, 1, 1, 0, 0);
    vecs[17] = mk(0, 0, 1, 1, 0,  3, 1, 1, 0, 0);
    vecs[18] = mk(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 1, 0,  0, 0, 0, 0, 0);
    vecs[20] = mk(0, 1, 0, 0, 0,  3, 1, 0, 0, 0);
    vecs[21] = mk(0, 1, 0, 1, 0,  3, 1, 0, 0, 0);

    for (int i = 0; i < 22; i++) begin
      cyc(vecs[i].r, vecs[i].gs, vecs[i].hit, vecs[i].heal, vecs[i].tick);
      check($sformatf("vec%0d_hp", i),     int'(bus.HP_value),   vecs[i].hp);
      check($sformatf("vec%0d_enable", i), int'(bus.HP_enable),  vecs[i].en);
      check($sformatf("vec%0d_invuln", i), int'(bus.invuln),     vecs[i].inv);
      check($sformatf("vec%0d_over", i),   int'(bus.gameover),   vecs[i].go);
      check($sformatf("vec%0d_dead", i),   int'(bus.dead_pulse), vecs[i].dp);
    end

    // Hit from HP 3, second hit 5 cycles later is ignored, then the full blink window.
    cyc(0, 0, 1, 0, 0);
    check("first_hit_hp", int'(bus.HP_value), 2);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("second_hit_hp", int'(bus.HP_value), 2);
    check("second_hit_inv", int'(bus.invuln), 1);
    for (int k = 1; k <= INV_FRAMES; k++) begin
      cyc(0, 0, 0, 0, 1);
      if (k < INV_FRAMES) begin
        check($sformatf("blink_tick%0d", k), int'(bus.HP_enable), ((INV_FRAMES - k) / 8) % 2);
        check("window_inv", int'(bus.invuln), 1);
      end
    end
    check("expire_inv", int'(bus.invuln), 0);
    check("expire_en", int'(bus.HP_enable), 1);
    check("expire_hp", int'(bus.HP_value), 2);

    // Down to HP 1, then a fatal hit.
    cyc(0, 0, 1, 0, 0);
    check("hp1", int'(bus.HP_value), 1);
    run_ticks(INV_FRAMES);
    check("hp1_alive", int'(bus.invuln), 0);
    cyc(0, 0, 1, 0, 0);
    check("death_hp", int'(bus.HP_value), 0);
    check("death_over", int'(bus.gameover), 1);
    check("death_pulse", int'(bus.dead_pulse), 1);
    cyc(0, 0, 0, 0, 0);
    check("death_pulse_once", int'(bus.dead_pulse), 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1);
    check("dead_hold_hp", int'(bus.HP_value), 0);
    check("dead_hold_over", int'(bus.gameover), 1);
    check("dead_hold_pulse", int'(bus.dead_pulse), 0);

    // Hit and heal together at HP 1 does not kill.
    cyc(0, 1, 0, 0, 0);
    check("restart_over", int'(bus.gameover), 0);
    cyc(0, 0, 1, 0, 0);
    run_ticks(INV_FRAMES);
    cyc(0, 0, 1, 0, 0);
    run_ticks(INV_FRAMES);
    check("pre_combo_hp", int'(bus.HP_value), 1);
    cyc(0, 0, 1, 1, 0);
    check("combo_hp", int'(bus.HP_value), 1);
    check("combo_inv", int'(bus.invuln), 1);
    check("combo_over", int'(bus.gameover), 0);

    // Reset in the middle of an invulnerability window.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 1);
    check("pre_rst_inv", int'(bus.invuln), 1);
    cyc(1, 0, 0, 0, 0);
    check("rst_hp", int'(bus.HP_value), 0);
    check("rst_inv", int'(bus.invuln), 0);
    check("rst_pulse", int'(bus.dead_pulse), 0);
    check("rst_over", int'(bus.gameover), 0);
    cyc(0, 1, 0, 0, 0);
    check("rst_restart_hp", int'(bus.HP_value), 3);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(199) == 0, $urandom_range(79) == 0,
          $urandom_range(5) == 0, $urandom_range(6) == 0, $urandom_range(2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hp_manager.md
Name: hp_manager

Overview:
- Tracks the player's hit points. Drives the HP_value and enable inputs of the HP heart-icon display stage, which sits directly downstream.
- Converts single-cycle hit and heal events from the game logic into a saturating HP count.
- Applies a post-hit invulnerability window, counted in VGA frames, during which the hearts blink.
- Raises gameover when HP reaches 0.

Parameters:
- HP_MAX, 5: ceiling for HP_value. This is also the number of heart slots the display draws.
- HP_INIT, 3: HP loaded on game_start. Must satisfy 1 <= HP_INIT <= HP_MAX.
- INVULN_FRAMES, 60: length of the invulnerability window after a non-fatal hit, in frame_tick pulses.
- BLINK_BIT, 3: bit of the invulnerability counter that gates HP_enable. The hearts toggle every 2^BLINK_BIT frames.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous, active-high reset.
- game_start  in  1  one-cycle pulse; (re)starts a game.
- hit_pulse  in  1  one-cycle pulse; player took damage.
- heal_pulse  in  1  one-cycle pulse; player collected a heart.
- frame_tick  in  1  one-cycle pulse per VGA frame (start of vertical blank).
- HP_value  out  3  current HP, 0..HP_MAX; feeds the display.
- HP_enable  out  1  display enable for the hearts; low while blinking off, idle or dead.
- invuln  out  1  high while hits are being ignored.
- gameover  out  1  level; high from death until the next game_start.
- dead_pulse  out  1  one-cycle pulse on the transition into DEAD.

Behaviour:
- All outputs are registered. Each updates on the clk edge after the causing input is sampled, i.e. latency 1 cycle.
- Reset (rst=1 at a clk edge) forces, overriding everything else:
  - state=IDLE
  - HP_value=0, HP_enable=0, invuln=0, gameover=0, dead_pulse=0
  - invulnerability counter inv_cnt=0
- Reset asserted mid-game drops straight to IDLE. No gameover or dead_pulse is generated.
- States: IDLE, ALIVE, INVULN, DEAD.
- game_start has priority over hit and heal in every state. It causes:
  - HP_value<=HP_INIT, inv_cnt<=0, gameover<=0, state<=ALIVE
  - hit_pulse and heal_pulse in the same cycle are ignored.
- IDLE: hit, heal and frame_tick are ignored.
- ALIVE, event handling in the same cycle is evaluated as hit then heal:
  - Hit only, HP_value>1: HP_value-1; inv_cnt<=INVULN_FRAMES; state<=INVULN.
  - Hit only, HP_value==1: HP_value<=0; state<=DEAD; gameover<=1; dead_pulse=1 for exactly one cycle.
  - Hit and heal together: HP unchanged and no death, even at HP 1. The hit still starts INVULN with inv_cnt<=INVULN_FRAMES.
  - Heal only: HP_value<=min(HP_value+1, HP_MAX). At HP_MAX it is a no-op.
- INVULN:
  - hit_pulse is ignored.
  - heal_pulse applies with the same saturation rule as ALIVE.
  - On frame_tick: if inv_cnt==1, inv_cnt<=0 and state<=ALIVE; otherwise inv_cnt decrements.
  - inv_cnt never wraps below 0.
  - A hit in the same cycle the counter expires is still ignored. The state reached is ALIVE.
- DEAD: HP_value=0 and gameover=1 are held. Hit, heal and frame_tick are ignored. Only game_start or rst exits.
- HP_enable by state:
  - IDLE: 0
  - ALIVE: 1
  - INVULN: inv_cnt[BLINK_BIT]
  - DEAD: 0
- invuln=1 exactly while state==INVULN.
- Width rules:
  - HP arithmetic is done in 3 bits; HP_MAX<=7 is enforced by elaboration check.
  - inv_cnt width is clog2(INVULN_FRAMES+1), and must have at least BLINK_BIT+1 bits.
- frame_tick coincident with a hit in ALIVE: the counter loads INVULN_FRAMES. That tick is not counted.

Test Plan:
- rst for 2 cycles, then idle 10 cycles -> HP_value=0, HP_enable=0, gameover=0. Hits and heals in IDLE have no effect.
- game_start, then heal x3 -> HP_value 3,4,5,5 (saturates). HP_enable=1, invuln=0.
- From HP 3: hit, then another hit 5 cycles later, then 60 frame_ticks -> HP 2 with invuln=1 and the second hit ignored. HP_enable toggles every 8 ticks. After the 60th tick invuln=0 and HP_value=2.
- From HP 1 in ALIVE: hit -> next cycle HP_value=0, gameover=1, dead_pulse high for exactly 1 cycle. Later heals and hits leave the outputs unchanged.
- From HP 1: hit and heal in the same cycle -> HP_value=1, state INVULN, gameover=0. Separately, game_start with a simultaneous hit -> HP_value=3, state ALIVE.
- In INVULN at HP 2: assert rst for one cycle -> all outputs 0, state IDLE, no dead_pulse. A following game_start gives HP_value=3.
